// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder feeding an instruction RAM write port.
// Accepts one request every two cycles, range-checks immediates and tracks fill level.
module instruction_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            format_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [4:0]            rd_i,
  input  logic [31:0]           imm_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  // True when bits [31:lsb] are a pure sign extension of bit lsb.
  function automatic logic sext_ok(input logic [31:0] v, input int lsb);
    logic ones, zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int b = 0; b < 32; b++) begin
      if (b >= lsb) begin
        ones  = ones & v[b];
        zeros = zeros & ~v[b];
      end
    end
    return ones | zeros;
  endfunction

  function automatic enc_t encode(input req_t r);
    enc_t e;
    e.legal = 1'b0;
    e.word  = 32'h0;
    case (r.fmt)
      FMT_R: begin
        e.legal = 1'b1;
        e.word  = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
      end
      FMT_I: begin
        e.legal = sext_ok(r.imm, 11);
        e.word  = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
      end
      FMT_S: begin
        e.legal = sext_ok(r.imm, 11);
        e.word  = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
      end
      FMT_B: begin
        e.legal = sext_ok(r.imm, 12) && !r.imm[0];
        e.word  = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                   r.imm[4:1], r.imm[11], r.opcode};
      end
      FMT_U: begin
        e.legal = (r.imm[11:0] == 12'h0);
        e.word  = {r.imm[31:12], r.rd, r.opcode};
      end
      FMT_J: begin
        e.legal = sext_ok(r.imm, 20) && !r.imm[0];
        e.word  = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
      end
      default: begin
        e.legal = 1'b0;
        e.word  = 32'h0;
      end
    endcase
    return e;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  we_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  req_t                  req;
  enc_t                  enc;
  logic                  accept;
  logic [ADDR_WIDTH:0]   count_next;

  assign req = '{fmt: format_i, opcode: opcode_i, funct3: funct3_i, funct7: funct7_i,
                 rs1: rs1_i, rs2: rs2_i, rd: rd_i, imm: imm_i};
  assign enc = encode(req);

  // A clear in the same cycle as valid_i wins, so the request is not taken.
  assign ready_o    = (state_q == IDLE) && !clear_i;
  assign accept     = valid_i && ready_o;
  assign count_next = count_q + {{ADDR_WIDTH{1'b0}}, we_q};

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = WRITE;
        WRITE:   state_d = (count_next == DEPTH_C) ? FULL : IDLE;
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Encoding happens at accept so the strobe and word are registered for the WRITE cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= 32'h0;
      count_q <= '0;
    end else if (clear_i) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE;
      count_q <= '0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      if (accept) begin
        we_q   <= enc.legal;
        err_q  <= !enc.legal;
        addr_q <= BASE + count_q[ADDR_WIDTH-1:0];
        if (enc.legal) wdata_q <= enc.word;
      end
      if (state_q == WRITE) count_q <= count_next;
    end
  end

  // clear_i cancels a strobe already registered for this cycle.
  assign mem_we_o    = we_q && !clear_i;
  assign err_o       = err_q && !clear_i;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == DEPTH_C);

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: default instance plus a DEPTH=4 instance
// whose base address sits near the top of the address space.
module tb_instruction_encoder;
  logic clk = 0, rst_n = 0;
  logic clear = 0, clear4 = 0, valid = 0, valid4 = 0;
  logic [2:0] fmt = 0, funct3 = 0;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [31:0] imm = 0;

  logic ready, we, err, full;
  logic [7:0] addr;
  logic [31:0] wdata;
  logic [8:0] count;
  logic ready4, we4, err4, full4;
  logic [7:0] addr4;
  logic [31:0] wdata4;
  logic [8:0] count4;

  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid), .ready_o(ready),
    .format_i(fmt), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm_i(imm),
    .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata), .err_o(err),
    .count_o(count), .full_o(full));

  instruction_encoder #(.ADDR_WIDTH(8), .DEPTH(4), .BASE_ADDR(8'hFE)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear4), .valid_i(valid4), .ready_o(ready4),
    .format_i(fmt), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .imm_i(imm),
    .mem_we_o(we4), .mem_addr_o(addr4), .mem_wdata_o(wdata4), .err_o(err4),
    .count_o(count4), .full_o(full4));

  // Call at a negedge; returns at the negedge inside the WRITE cycle.
  task automatic drive(input bit d4, input logic [2:0] f, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rdd, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = rdd; imm = im;
    if (d4) valid4 = 1; else valid = 1;
    @(posedge clk); #1;
    valid = 0; valid4 = 0;
    fmt = 3'd6; opcode = '1; funct3 = '1; funct7 = '1; rs1 = '1; rs2 = '1; rd = '1; imm = '1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0b exp 1", ready); end
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL rst_we got %0b exp 0", we); end
    checks++; if (addr !== 8'h00) begin fails++; $display("FAIL rst_addr got %h exp 00", addr); end
    checks++; if (wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata got %h exp 0", wdata); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %0b exp 0", err); end
    checks++; if (count !== 9'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL rst_full got %0b exp 0", full); end
    checks++; if (addr4 !== 8'hFE) begin fails++; $display("FAIL rst_addr4 got %h exp fe", addr4); end
  endtask

  task automatic test_i_type;
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL i_ready_pre got %0b exp 1", ready); end
    drive(0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL i_ready_write got %0b exp 0", ready); end
    checks++; if (we !== 1'b1) begin fails++; $display("FAIL i_we got %0b exp 1", we); end
    checks++; if (addr !== 8'd0) begin fails++; $display("FAIL i_addr got %h exp 00", addr); end
    checks++; if (wdata !== 32'h00500093) begin fails++; $display("FAIL i_wdata got %h exp 00500093", wdata); end
    @(negedge clk);
    checks++; if (count !== 9'd1) begin fails++; $display("FAIL i_count got %0d exp 1", count); end
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL i_we_after got %0b exp 0", we); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL i_ready_after got %0b exp 1", ready); end
  endtask

  task automatic test_back_to_back;
    drive(0, 3'd0, 7'h33, 3'd0, 7'h0, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL r_ready got %0b exp 0", ready); end
    checks++; if (we !== 1'b1 || addr !== 8'd1 || wdata !== 32'h002081B3)
      begin fails++; $display("FAIL r_write got we=%0b addr=%h data=%h exp 1/01/002081b3", we, addr, wdata); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %0b exp 1", ready); end
    drive(0, 3'd2, 7'h23, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd31, 32'd8);
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL s_ready got %0b exp 0", ready); end
    checks++; if (we !== 1'b1 || addr !== 8'd2 || wdata !== 32'h0020A423)
      begin fails++; $display("FAIL s_write got we=%0b addr=%h data=%h exp 1/02/0020a423", we, addr, wdata); end
    @(negedge clk);
    checks++; if (count !== 9'd3) begin fails++; $display("FAIL s_count got %0d exp 3", count); end
  endtask

  task automatic test_bju;
    logic [2:0]  f [3]  = '{3'd3, 3'd4, 3'd5};
    logic [6:0]  op [3] = '{7'h63, 7'h37, 7'h6F};
    logic [4:0]  rdv [3] = '{5'd0, 5'd5, 5'd1};
    logic [31:0] im [3] = '{32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0800};
    logic [31:0] ex [3] = '{32'hFE208EE3, 32'h123452B7, 32'h001000EF};
    for (int k = 0; k < 3; k++) begin
      drive(0, f[k], op[k], 3'd0, 7'h0, 5'd1, 5'd2, rdv[k], im[k]);
      checks++; if (we !== 1'b1 || addr !== 8'(3 + k) || wdata !== ex[k])
        begin fails++; $display("FAIL bju%0d got we=%0b addr=%h data=%h exp data %h", k, we, addr, wdata, ex[k]); end
      @(negedge clk);
      checks++; if (count !== 9'(4 + k)) begin fails++; $display("FAIL bju%0d_count got %0d exp %0d", k, count, 4 + k); end
    end
  endtask

  task automatic test_illegal;
    logic [2:0]  f [4]  = '{3'd1, 3'd3, 3'd4, 3'd7};
    logic [31:0] im [4] = '{32'd2048, 32'd3, 32'h1001, 32'd0};
    for (int k = 0; k < 4; k++) begin
      drive(0, f[k], 7'h13, 3'd0, 7'h0, 5'd1, 5'd2, 5'd3, im[k]);
      checks++; if (err !== 1'b1 || we !== 1'b0)
        begin fails++; $display("FAIL ill%0d got err=%0b we=%0b exp err=1 we=0", k, err, we); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || count !== 9'd6 || ready !== 1'b1)
        begin fails++; $display("FAIL ill%0d_after got err=%0b count=%0d ready=%0b exp 0/6/1", k, err, count, ready); end
    end
  endtask

  task automatic test_full;
    logic [7:0] ea [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int k = 0; k < 4; k++) begin
      drive(1, 3'd4, 7'h37, 3'd0, 7'h0, 5'd0, 5'd0, 5'(k), 32'h0000_1000 * (k + 1));
      checks++; if (we4 !== 1'b1 || addr4 !== ea[k])
        begin fails++; $display("FAIL full_w%0d got we=%0b addr=%h exp 1/%h", k, we4, addr4, ea[k]); end
      @(negedge clk);
    end
    checks++; if (full4 !== 1'b1 || ready4 !== 1'b0 || count4 !== 9'd4)
      begin fails++; $display("FAIL full_state got full=%0b ready=%0b count=%0d exp 1/0/4", full4, ready4, count4); end
    drive(1, 3'd0, 7'h33, 3'd0, 7'h0, 5'd1, 5'd2, 5'd3, 32'd0);
    checks++; if (we4 !== 1'b0 || count4 !== 9'd4 || full4 !== 1'b1)
      begin fails++; $display("FAIL full_ignore got we=%0b count=%0d full=%0b exp 0/4/1", we4, count4, full4); end
    clear4 = 1;
    @(posedge clk); #1 clear4 = 0;
    @(negedge clk);
    checks++; if (count4 !== 9'd0 || full4 !== 1'b0 || ready4 !== 1'b1 || addr4 !== 8'hFE)
      begin fails++; $display("FAIL full_clear got count=%0d full=%0b ready=%0b addr=%h exp 0/0/1/fe", count4, full4, ready4, addr4); end
    drive(1, 3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    checks++; if (we4 !== 1'b1 || addr4 !== 8'hFE || wdata4 !== 32'h00500093)
      begin fails++; $display("FAIL full_rewrite got we=%0b addr=%h data=%h exp 1/fe/00500093", we4, addr4, wdata4); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write;
    drive(0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    checks++; if (we !== 1'b1) begin fails++; $display("FAIL rmw_pre got we=%0b exp 1", we); end
    #2 rst_n = 0;
    #1;
    checks++; if (we !== 1'b0 || count !== 9'd0 || ready !== 1'b1 || addr !== 8'd0 ||
                  wdata !== 32'h0 || err !== 1'b0 || full !== 1'b0)
      begin fails++; $display("FAIL rmw got we=%0b count=%0d ready=%0b addr=%h data=%h err=%0b full=%0b exp reset values",
                              we, count, ready, addr, wdata, err, full); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    checks++; if (count !== 9'd0 || we !== 1'b0) begin fails++; $display("FAIL rmw_after got count=%0d we=%0b exp 0/0", count, we); end
  endtask

  task automatic test_clear_mid_write;
    drive(0, 3'd0, 7'h33, 3'd0, 7'h0, 5'd1, 5'd2, 5'd3, 32'd0);
    @(negedge clk);
    drive(0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    clear = 1;
    #1;
    checks++; if (we !== 1'b0) begin fails++; $display("FAIL cmw_we got %0b exp 0", we); end
    @(posedge clk); #1 clear = 0;
    @(negedge clk);
    checks++; if (count !== 9'd0 || ready !== 1'b1 || we !== 1'b0)
      begin fails++; $display("FAIL cmw_after got count=%0d ready=%0b we=%0b exp 0/1/0", count, ready, we); end
    drive(0, 3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5);
    checks++; if (we !== 1'b1 || addr !== 8'd0) begin fails++; $display("FAIL cmw_rewrite got we=%0b addr=%h exp 1/00", we, addr); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_i_type;
    test_back_to_back;
    test_bju;
    test_illegal;
    test_full;
    test_reset_mid_write;
    test_clear_mid_write;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs field-level RISC-V RV32I instruction descriptions (format, opcode, funct3/funct7, register indices, immediate) into 32-bit machine words and writes them sequentially into instruction memory. It sits between the program-load source (debug/UART loader, test sequencer) and the instruction RAM write port. It is the inverse of the instruction decoder: every word it writes, when decoded, reproduces the accepted fields and the sign-extended immediate. It range-checks immediates, rejects unencodable requests, and tracks fill level against a fixed capacity.

## Interface
- ADDR_WIDTH, 8: word-address width of the instruction memory.
- DEPTH, 256: number of words that may be written before full; must be ≤ 2^ADDR_WIDTH.
- BASE_ADDR, 0: word address of the first write after reset or clear.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous restart: address to BASE_ADDR, count to 0, leave FULL.
- valid_i  in  1  request valid.
- ready_o  out  1  encoder can accept a request.
- format_i  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- opcode_i  in  7  opcode field.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field (R only).
- rs1_i, rs2_i, rd_i  in  5 each  register indices.
- imm_i  in  32  full-value signed immediate (byte offset; U is the final upper value).
- mem_we_o  out  1  instruction memory write strobe.
- mem_addr_o  out  ADDR_WIDTH  word address.
- mem_wdata_o  out  32  encoded instruction.
- err_o  out  1  one-cycle pulse: request rejected, nothing written.
- count_o  out  ADDR_WIDTH+1  words written since reset/clear.
- full_o  out  1  count_o == DEPTH.

## Operation
- States: IDLE, WRITE, FULL. ready_o = 1 only in IDLE.
- IDLE: on valid_i && ready_o, register all fields; go to WRITE.
- WRITE (one cycle): if request legal, mem_we_o=1, mem_addr_o=BASE_ADDR+count, mem_wdata_o=encoded word; count increments. If illegal, err_o=1, mem_we_o=0, count unchanged. Next state FULL if new count == DEPTH, else IDLE.
- FULL: ready_o=0, full_o=1; leaves only via clear_i or reset.
- Encoding (bits MSB→LSB): R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}. Unused fields ignored.
- Legality: I,S need imm[31:11] all equal; B needs imm[31:12] all equal and imm[0]=0; U needs imm[11:0]=0; J needs imm[31:20] all equal and imm[0]=0; R always legal; format 6/7 illegal.
- mem_addr_o arithmetic is modulo 2^ADDR_WIDTH.
- clear_i has priority over any state, including WRITE: the pending write is dropped (mem_we_o forced 0 that cycle); next cycle is IDLE with count 0.

## Timing
- Reset values: state IDLE, ready_o=1, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_wdata_o=0, err_o=0, count_o=0, full_o=0.
- Accept at edge N; write strobe/err_o valid in cycle N+1; ready_o returns in cycle N+2 (unless FULL). Peak throughput: one instruction per 2 cycles.
- mem_we_o, mem_addr_o, mem_wdata_o, err_o are registered; count_o/full_o update on the edge ending WRITE.
- Reset asserted mid-WRITE: write strobe deasserts immediately (async), request lost, count 0.
- valid_i with ready_o=0 is ignored; fields need hold only in the accept cycle.

## Test plan
- Reset, then I: opcode 0x13, funct3 0, rd 1, rs1 0, imm 5 → cycle+1 mem_we_o=1, addr 0, wdata 0x00500093; count_o=1.
- Back-to-back R add (0x33, rd 3, rs1 1, rs2 2, funct7 0), S sw (0x23, funct3 2, rs1 1, rs2 2, imm 8) → addr 1 = 0x002081B3, addr 2 = 0x0020A423; ready_o low every other cycle.
- B beq (0x63, rs1 1, rs2 2, imm −4) → 0xFE208EE3; U lui (0x37, rd 5, imm 0x12345000) → 0x123452B7; J jal (0x6F, rd 1, imm 0x800) → 0x001000EF.
- Illegal: I imm 2048, B imm 3, U imm 0x1001, format 7 → each err_o one-cycle pulse, mem_we_o=0, count unchanged.
- DEPTH=4: four legal writes → full_o=1, ready_o=0, further valid_i ignored; clear_i → count 0, next write at BASE_ADDR.
- Assert rst_ni low during WRITE cycle → mem_we_o drops in same cycle; all outputs at reset values; clear_i during WRITE → no write, count 0.
